nn_job_sequencer: RTL and testbench
===================================

NN_JOB_SEQUENCER -- requirements
Module: nn_job_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the matrix element width; in_data/mat_A carry 4*WIDTH bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent waiting for mat_done.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two), giving the result FIFO depth.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 4*WIDTH): the job input handshake; in_data is a packed 2x2 matrix, element [0][0] in the MSBs.
REQ-007 The block SHALL have port mat_A, output, 4*WIDTH: the operand driven to the matrix core.
REQ-008 The block SHALL have ports mat_start (output, 1), mat_done (input, 1) and mat_done_ack (output, 1): the core handshake.
REQ-009 The block SHALL have port mat_res, input, 64: the core result; only bits [31:0] are meaningful.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32): the result stream from the FIFO head.
REQ-011 The block SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port timeout_err, output, 1: sticky timeout flag.
REQ-013 The block SHALL have port job_count, output, 16: the number of completed jobs.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_DONE, ACK.
REQ-015 in_ready SHALL be 1 only in IDLE when the FIFO is not full and mat_done=0.
REQ-016 When in IDLE and in_valid&in_ready, the block SHALL register in_data into mat_A and go to LAUNCH.
REQ-017 mat_A SHALL be held stable until the next accepted job.
REQ-018 In LAUNCH, mat_start SHALL be 1 for exactly one cycle; the next state is WAIT_DONE and the timeout counter clears to 0.
REQ-019 In WAIT_DONE with mat_done=1, the block SHALL push mat_res[31:0] into the FIFO, increment job_count (wrapping at 16 bits) and go to ACK.
REQ-020 In WAIT_DONE with mat_done=0, the timeout counter SHALL increment.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1 with mat_done=0, the block SHALL set timeout_err, push nothing and go to ACK.
REQ-022 In ACK, mat_done_ack SHALL be 1; the block SHALL return to IDLE on the first cycle mat_done=0.
REQ-023 mat_done_ack SHALL be 0 in all states other than ACK.
REQ-024 Launch-to-done latency SHALL be unconstrained up to the timeout; a minimum of 1 cycle is legal.
REQ-025 The FIFO SHALL pop when out_valid&out_ready.
REQ-026 out_valid SHALL equal FIFO not-empty, and out_data SHALL be the FIFO head.
REQ-027 A simultaneous push and pop SHALL leave the occupancy unchanged and remain legal when the FIFO is full.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 A push to a full FIFO SHALL be impossible by construction (REQ-015: at most one job in flight, accepted only when not full).
REQ-030 timeout_err SHALL clear only on reset.
REQ-031 mat_done asserted outside WAIT_DONE/ACK SHALL be ignored and SHALL hold off acceptance.

Reset
REQ-032 When reset=0 at a clock edge, the FSM SHALL go to IDLE and FIFO pointers/occupancy, timeout counter, job_count, timeout_err and mat_A SHALL clear to 0.
REQ-033 After reset: in_ready=1 (if mat_done=0), mat_start=0, mat_done_ack=0, out_valid=0, busy=0.
REQ-034 A reset mid-job SHALL abandon the job with no push; the core is reset by the same signal.

Structure
REQ-035 The FSM state encodings, the 64-bit result width and the default TIMEOUT_CYCLES/FIFO_DEPTH SHALL live in shared package nn_pkg.
REQ-036 The result FIFO SHALL be sub-module nn_res_fifo (synchronous, parameterised width/depth, full/empty flags).

Verification
REQ-037 Basic job: with the matrix core attached, in_data=0x01020304 -> mat_start pulses once, and out_data=0x0B0C0D0E with job_count=1.
REQ-038 Back-pressure: out_ready=0 with 5 jobs offered -> 4 results are queued, in_ready stays 0 with the 5th pending; one pop -> the 5th is accepted, results come out in order.
REQ-039 Timeout: a core stub never asserts mat_done -> after 64 WAIT_DONE cycles timeout_err=1, mat_done_ack pulses, no push, and job_count is unchanged.
REQ-040 Stuck done: the stub holds mat_done=1 for 3 cycles after ack -> the FSM stays in ACK 3 cycles, then IDLE.
REQ-041 Reset mid-job: reset=0 during WAIT_DONE -> next cycle IDLE, out_valid=0, job_count=0.
REQ-042 Simultaneous push/pop with the FIFO full -> occupancy stays 4, and data order is preserved across the pointer wrap.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the NN job sequencer: FSM states, result widths and
// default sizing for the timeout and result FIFO.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam int RES_W                  = 64;
  localparam int OUT_W                  = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

endpackage

// File: rtl/nn_res_fifo.sv
// Synchronous result FIFO with full/empty flags; depth must be a power of two
// so the pointers wrap naturally.
module nn_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push+pop on a full FIFO is legal.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + ONE_COUNT;
        2'b01:   count_reg <= count_reg - ONE_COUNT;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/nn_job_sequencer.sv
// Sequences 2x2 matrix jobs into an external core one at a time, with a done
// timeout, and queues the 32-bit results in a small FIFO.
module nn_job_sequencer
  import nn_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [4*WIDTH-1:0] mat_A,
  output logic               mat_start,
  input  logic               mat_done,
  output logic               mat_done_ack,
  input  logic [RES_W-1:0]   mat_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        job_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TC_ONE  = TW'(1);

  state_t             state_reg, state_next;
  logic [4*WIDTH-1:0] mat_a_reg, mat_a_next;
  logic [TW-1:0]      tcnt_reg, tcnt_next;
  logic [15:0]        job_count_reg, job_count_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               unused_res;

  assign unused_res = ^mat_res[RES_W-1:OUT_W];

  // Only one job is ever in flight and it is accepted only with a free slot,
  // so the result push can never hit a full FIFO.
  assign in_ready    = (state_reg == IDLE) && !fifo_full && !mat_done;
  assign busy        = (state_reg != IDLE);
  assign mat_A       = mat_a_reg;
  assign job_count   = job_count_reg;
  assign timeout_err = timeout_err_reg;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      mat_a_reg       <= '0;
      tcnt_reg        <= '0;
      job_count_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mat_a_reg       <= mat_a_next;
      tcnt_reg        <= tcnt_next;
      job_count_reg   <= job_count_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    mat_a_next       = mat_a_reg;
    tcnt_next        = tcnt_reg;
    job_count_next   = job_count_reg;
    timeout_err_next = timeout_err_reg;
    push             = 1'b0;
    mat_start        = 1'b0;
    mat_done_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          mat_a_next = in_data;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        mat_start  = 1'b1;
        tcnt_next  = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mat_done) begin
          push           = 1'b1;
          job_count_next = job_count_reg + 16'd1;
          state_next     = ACK;
        end else if (tcnt_reg == TC_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = ACK;
        end else begin
          tcnt_next = tcnt_reg + TC_ONE;
        end
      end
      ACK: begin
        mat_done_ack = 1'b1;
        if (!mat_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  nn_res_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mat_res[OUT_W-1:0]),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_nn_job_sequencer.sv
// Self-checking bench: a behavioural core stub (adds 10 to each element), a
// result scoreboard, table-driven jobs, corner-case sequences and random jobs.
module tb_nn_job_sequencer;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] mat_A;
  logic        mat_start;
  logic        mat_done;
  logic        mat_done_ack;
  logic [63:0] mat_res = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  logic        timeout_err;
  logic [15:0] job_count;

  logic        f_push = 1'b0, f_pop = 1'b0;
  logic [31:0] f_wdata = '0;
  logic [31:0] f_rdata;
  logic        f_full, f_empty;

  logic        stub_done = 1'b0;
  logic        stub_force = 1'b0;
  assign mat_done = stub_done | stub_force;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          exp_jobs = 0;
  int          rdy_mode = 2;
  int          pops_allowed = 0;
  int          stub_lat = 1;
  int          stub_hold = 1;
  bit          stub_never = 1'b0;
  int          s_cnt = 0;
  int          s_acks = 0;
  bit          s_pend = 1'b0;
  logic [31:0] s_a = '0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          hold;
    logic [31:0] res;
  } vec_t;

  always #5 clk = ~clk;

  nn_job_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mat_A        (mat_A),
    .mat_start    (mat_start),
    .mat_done     (mat_done),
    .mat_done_ack (mat_done_ack),
    .mat_res      (mat_res),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .job_count    (job_count)
  );

  nn_res_fifo #(.WIDTH(32), .DEPTH(4)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (f_push),
    .push_data (f_wdata),
    .pop       (f_pop),
    .pop_data  (f_rdata),
    .full      (f_full),
    .empty     (f_empty)
  );

  function automatic logic [31:0] core_fn(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + 8'd10;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Core stub: result after stub_lat cycles, done held for stub_hold ack cycles.
  always @(negedge clk) begin
    if (!reset) begin
      s_pend = 1'b0;
      stub_done = 1'b0;
      s_acks = 0;
    end else if (mat_start) begin
      s_pend = !stub_never;
      s_cnt = stub_lat;
      s_acks = 0;
      s_a = mat_A;
    end else if (s_pend) begin
      s_cnt--;
      if (s_cnt <= 0) begin
        s_pend = 1'b0;
        stub_done = 1'b1;
        mat_res = {$urandom(), core_fn(s_a)};
      end
    end else if (stub_done && mat_done_ack) begin
      s_acks++;
      if (s_acks >= stub_hold) stub_done = 1'b0;
    end
  end

  // Result sink and scoreboard; the transfer completes on the following posedge.
  always @(negedge clk) begin
    if (!reset) begin
      out_ready = 1'b0;
      exp_q.delete();
    end else begin
      case (rdy_mode)
        0:       out_ready = (pops_allowed > 0);
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        if (rdy_mode == 0) pops_allowed--;
        if (exp_q.size() == 0) check("unexpected_result", out_data, 64'hDEAD_0000_0000);
        else check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1 reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send_job(input logic [31:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] d, input int exp_wait, input int exp_acks);
    bit ok, seen;
    int starts, waits, acks;
    send_job(d, ok);
    check("accept", ok, 1);
    starts = 0; waits = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (mat_start) starts++;
      else if (mat_done_ack) seen = 1'b1;
      else if (busy) waits++;
    end
    check("ack_seen", seen, 1);
    check("start_pulses", starts, 1);
    check("wait_cycles", waits, exp_wait);
    check("mat_A_hold", mat_A, d);
    acks = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mat_done_ack) break;
      acks++;
    end
    check("ack_cycles", acks, exp_acks);
    check("idle_after_ack", busy, 0);
    check("job_count", job_count, exp_jobs);
    $display("job in=%h wait=%0d ack=%0d count=%0d err=%0b", d, waits, acks, job_count, timeout_err);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
    check("empty_after_drain", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] d;
    logic [31:0] fq[$];
    bit          ok;

    vecs[0] = '{32'h01020304, 3, 1, 32'h0B0C0D0E};
    vecs[1] = '{32'h00000000, 1, 1, 32'h0A0A0A0A};
    vecs[2] = '{32'hF6F7F8F9, 5, 2, 32'h00010203};
    vecs[3] = '{32'hFFFFFFFF, 2, 1, 32'h09090909};
    vecs[4] = '{32'h12345678, 10, 3, 32'h1C3E6082};

    apply_reset(2);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mat_start", mat_start, 0);
    check("rst_ack", mat_done_ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_job_count", job_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_mat_A", mat_A, 0);

    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      stub_lat = vecs[i].lat;
      stub_hold = vecs[i].hold;
      exp_q.push_back(vecs[i].res);
      exp_jobs++;
      run_job(vecs[i].data, vecs[i].lat, vecs[i].hold);
      wait_drain();
    end

    // Back-pressure: four results fill the FIFO, the fifth job waits for a pop.
    rdy_mode = 0; pops_allowed = 0; stub_lat = 2; stub_hold = 1;
    for (int k = 0; k < 4; k++) begin
      d = $urandom();
      exp_q.push_back(core_fn(d));
      exp_jobs++;
      run_job(d, 2, 1);
    end
    d = $urandom();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    repeat (8) @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", out_data, exp_q[0]);
    exp_q.push_back(core_fn(d));
    exp_jobs++;
    pops_allowed = 1;
    run_job(d, 2, 1);
    rdy_mode = 2;
    wait_drain();

    // mat_done high while idle must be ignored and block acceptance.
    stub_force = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hCAFE0001;
    repeat (3) begin
      @(negedge clk);
      check("done_idle_ready", in_ready, 0);
      check("done_idle_busy", busy, 0);
    end
    in_valid = 1'b0;
    stub_force = 1'b0;
    @(negedge clk);
    check("done_idle_release", in_ready, 1);
    check("done_idle_count", job_count, exp_jobs);

    // Timeout: core never answers.
    check("pre_timeout_err", timeout_err, 0);
    stub_never = 1'b1; stub_hold = 1;
    run_job(32'h55AA55AA, 64, 1);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_no_push", out_valid, 0);
    stub_never = 1'b0; stub_lat = 1;
    exp_q.push_back(core_fn(32'h01010101));
    exp_jobs++;
    run_job(32'h01010101, 1, 1);
    check("timeout_err_sticky", timeout_err, 1);
    wait_drain();

    // Random jobs against the scoreboard with random sink back-pressure.
    rdy_mode = 1;
    for (int k = 0; k < 20; k++) begin
      d = $urandom();
      stub_lat = $urandom_range(1, 8);
      stub_hold = $urandom_range(1, 3);
      exp_q.push_back(core_fn(d));
      exp_jobs++;
      run_job(d, stub_lat, stub_hold);
    end
    wait_drain();

    // Reset in the middle of a job with a result still queued.
    rdy_mode = 0; pops_allowed = 0; stub_lat = 1; stub_hold = 1;
    exp_q.push_back(core_fn(32'h0F0F0F0F));
    exp_jobs++;
    run_job(32'h0F0F0F0F, 1, 1);
    check("pre_reset_out_valid", out_valid, 1);
    stub_lat = 30;
    send_job(32'h77777777, ok);
    check("midjob_accept", ok, 1);
    repeat (5) @(negedge clk);
    check("midjob_busy", busy, 1);
    apply_reset(1);
    exp_jobs = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_job_count", job_count, 0);
    check("midrst_timeout_err", timeout_err, 0);
    check("midrst_mat_A", mat_A, 0);
    check("midrst_in_ready", in_ready, 1);
    rdy_mode = 2; stub_lat = 1;
    exp_q.push_back(core_fn(32'h20304050));
    exp_jobs++;
    run_job(32'h20304050, 1, 1);
    wait_drain();

    // Result FIFO alone: push+pop while full keeps it full, order survives the wrap.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f_push = 1'b1;
      f_wdata = $urandom();
      fq.push_back(f_wdata);
    end
    @(negedge clk);
    f_push = 1'b0;
    check("fifo_full", f_full, 1);
    check("fifo_not_empty", f_empty, 0);
    for (int i = 0; i < 6; i++) begin
      check("fifo_pp_head", f_rdata, fq[0]);
      f_push = 1'b1;
      f_pop = 1'b1;
      f_wdata = $urandom();
      void'(fq.pop_front());
      fq.push_back(f_wdata);
      @(negedge clk);
      f_push = 1'b0;
      f_pop = 1'b0;
      check("fifo_pp_full", f_full, 1);
    end
    for (int i = 0; i < 4; i++) begin
      check("fifo_drain_data", f_rdata, fq.pop_front());
      f_pop = 1'b1;
      @(negedge clk);
      f_pop = 1'b0;
    end
    check("fifo_empty", f_empty, 1);
    check("fifo_not_full", f_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
